// File: rtl/aes_pkg.sv
// Shared AES definitions for the key schedule: sizes, round-constant seed, word and block
// types, the GF(2^8) doubling helper (xtime) and the forward S-box table.
// Bit order is big-endian throughout: byte 0 is bits [0:7], word 0 is bits [0:31].
package aes_pkg;

  localparam int unsigned AES_NR     = 10;  // rounds for AES-128
  localparam int unsigned AES_NK     = 4;   // key length in 32-bit words
  localparam logic [7:0]  RCON_INIT  = 8'h01;
  localparam logic [7:0]  XTIME_POLY = 8'h1B;

  typedef logic [0:31]  aes_word_t;
  typedef logic [0:127] aes_block_t;

  typedef enum logic [1:0] {
    StIdle,
    StExpand,
    StReady
  } ks_state_e;

  // Forward S-box, entry i is bits [8*i : 8*i+7].
  localparam logic [0:2047] SBOX_FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Multiply by x in GF(2^8): 8'h80 -> 8'h1B.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? XTIME_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
    return SBOX_FWD[{b, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/aes_sub_word.sv
// SubWord for the key schedule: forward S-box applied to each byte of a 32-bit word.
// Purely combinational; this is the forward table, not the inverse one used by the rounds.
// Ports:
//   word_i  input  [0:31]  word to substitute
//   word_o  output [0:31]  substituted word
module aes_sub_word
  import aes_pkg::*;
(
  input  aes_word_t word_i,
  output aes_word_t word_o
);

  always_comb begin
    word_o = '0;
    for (int i = 0; i < 4; i++) begin
      word_o[8*i +: 8] = sbox_fwd(word_i[8*i +: 8]);
    end
  end

endmodule

// File: rtl/aes_inv_key_sched.sv
// AES-128 key schedule and round-key store feeding the inverse cipher rounds.
// A start pulse loads cipher_key as round key 0, then one round key is derived per cycle
// until all 11 are held; any entry can then be read by index with one cycle of latency.
// Build option: define AES_KEYSCHED_ZEROIZE_EN to clear the whole store on reset and on
// every accepted start, so no key material from a previous key survives a rekey.
// Ports:
//   Clk         input         clock, rising edge
//   Reset       input         synchronous active-high reset
//   start       input         load cipher_key and begin expansion (ignored while busy)
//   cipher_key  input [0:127] key sampled when start is accepted
//   busy        output        expansion in progress
//   ready       output        all 11 round keys valid
//   rd_idx      input [3:0]   round-key index 0..10
//   round_key   output[0:127] registered store[rd_idx]; 0 when not ready or index > 10
module aes_inv_key_sched
  import aes_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = 10,
  parameter int unsigned KEY_W      = 128
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             start,
  input  logic [0:KEY_W-1] cipher_key,
  output logic             busy,
  output logic             ready,
  input  logic [3:0]       rd_idx,
  output logic [0:KEY_W-1] round_key
);

  if (NUM_ROUNDS != AES_NR || KEY_W != 128) begin : gen_param_check
    $error("aes_inv_key_sched supports only AES-128 (NUM_ROUNDS=10, KEY_W=128)");
  end

  localparam int unsigned NumKeys = AES_NR + 1;
  localparam logic [3:0]  LastIdx = 4'(AES_NR);

  ks_state_e  state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] rcon_q, rcon_d;
  aes_block_t store_q [NumKeys];

  logic       load;
  logic       expand_we;
  logic [3:0] prev_idx;
  aes_block_t prev_key;
  aes_word_t  rot_word, sub_word, temp;
  aes_word_t  n0, n1, n2, n3;
  aes_block_t next_key;

  // Round derivation from the previously written entry.
  always_comb begin
    prev_idx = cnt_q - 4'd1;
    prev_key = (prev_idx <= LastIdx) ? store_q[prev_idx] : '0;
    rot_word = {prev_key[104:127], prev_key[96:103]};
  end

  aes_sub_word u_sub_word (
    .word_i (rot_word),
    .word_o (sub_word)
  );

  always_comb begin
    temp     = sub_word ^ {rcon_q, 24'h0};
    n0       = prev_key[0:31]   ^ temp;
    n1       = prev_key[32:63]  ^ n0;
    n2       = prev_key[64:95]  ^ n1;
    n3       = prev_key[96:127] ^ n2;
    next_key = {n0, n1, n2, n3};
  end

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rcon_d    = rcon_q;
    load      = 1'b0;
    expand_we = 1'b0;
    unique case (state_q)
      StIdle, StReady: begin
        if (start) begin
          load    = 1'b1;
          state_d = StExpand;
          cnt_d   = 4'd1;
          rcon_d  = RCON_INIT;
        end
      end
      StExpand: begin
        expand_we = 1'b1;
        cnt_d     = cnt_q + 4'd1;
        rcon_d    = xtime(rcon_q);
        if (cnt_q == LastIdx) begin
          state_d = StReady;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy  = (state_q == StExpand);
  assign ready = (state_q == StReady);

  // Control registers and read port. The read uses the current ready, so a read issued
  // on the same cycle as a restart still returns the old key.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      rcon_q    <= RCON_INIT;
      round_key <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rcon_q    <= rcon_d;
      round_key <= (ready && rd_idx <= LastIdx) ? store_q[rd_idx] : '0;
    end
  end

  // Round-key store; no reset unless zeroization is built in.
  always_ff @(posedge Clk) begin
`ifdef AES_KEYSCHED_ZEROIZE_EN
    if (Reset || load) begin
      for (int i = 0; i < NumKeys; i++) begin
        store_q[i] <= '0;
      end
    end
`endif
    if (!Reset) begin
      if (load) begin
        store_q[0] <= cipher_key;
      end else if (expand_we) begin
        store_q[cnt_q] <= next_key;
      end
    end
  end

endmodule

// File: tb/tb_aes_inv_key_sched.sv
module tb_aes_inv_key_sched;

  logic         Clk = 1'b0;
  logic         Reset;
  logic         start;
  logic [0:127] cipher_key;
  logic         busy;
  logic         ready;
  logic [3:0]   rd_idx;
  logic [0:127] round_key;

  always #5 Clk = ~Clk;

  aes_inv_key_sched #(
    .NUM_ROUNDS (10),
    .KEY_W      (128)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .start      (start),
    .cipher_key (cipher_key),
    .busy       (busy),
    .ready      (ready),
    .rd_idx     (rd_idx),
    .round_key  (round_key)
  );

  localparam logic [0:127] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [0:127] K2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [0:127] K0 = 128'h0;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit mon_en   = 1'b0;

  typedef struct {
    logic [0:127] exp;
    int           due;
    string        name;
  } sb_t;
  sb_t sbq[$];
  sb_t cur;

  typedef struct {
    string        name;
    logic [0:127] key;
    logic [3:0]   idx;
    logic [0:127] exp;
  } vec_t;
  vec_t vecs[8];

  // Reference model: S-box built from GF(2^8) inverse plus affine map.
  logic [7:0]   sb_ref [256];
  logic [0:127] ks [0:10];

  always @(posedge Clk) cyc <= cyc + 1;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [7:0] r;
    r = b;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  task automatic build_sbox;
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(a), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sb_ref[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic compute_sched(input logic [0:127] key);
    logic [0:31]  w3, rot, t, a0, a1, a2, a3;
    logic [7:0]   rc;
    ks[0] = key;
    rc    = 8'h01;
    for (int r = 1; r <= 10; r++) begin
      w3  = ks[r-1][96:127];
      rot = {w3[8:31], w3[0:7]};
      t   = {sb_ref[rot[0:7]], sb_ref[rot[8:15]], sb_ref[rot[16:23]], sb_ref[rot[24:31]]};
      t   = t ^ {rc, 24'h0};
      a0  = ks[r-1][0:31] ^ t;
      a1  = ks[r-1][32:63] ^ a0;
      a2  = ks[r-1][64:95] ^ a1;
      a3  = ks[r-1][96:127] ^ a2;
      ks[r] = {a0, a1, a2, a3};
      rc  = gmul(rc, 8'h02);
    end
  endtask

  task automatic chk(input string name, input logic [0:127] act, input logic [0:127] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  // Drive a read; its expected value is due one edge later.
  task automatic rd(input logic [3:0] idx, input logic [0:127] exp, input string name);
    sb_t e;
    rd_idx = idx;
    e.exp  = exp;
    e.due  = cyc + 1;
    e.name = name;
    sbq.push_back(e);
    tick;
  endtask

  task automatic load(input logic [0:127] key);
    start      = 1'b1;
    cipher_key = key;
    tick;
    start      = 1'b0;
    cipher_key = ~key;
  endtask

  // Called right after load (cycle 1); returns cycle on which ready was seen.
  task automatic wait_ready(output int n);
    n = 1;
    while (!ready && n < 40) begin
      tick;
      n++;
    end
  endtask

  always @(negedge Clk) begin
    if (mon_en) begin
      chk("busy_ready_excl", 128'(busy & ready), 128'h0);
      while (sbq.size() > 0 && sbq[0].due <= cyc) begin
        cur = sbq.pop_front();
        chk(cur.name, round_key, cur.exp);
      end
    end
  end

  initial begin
    int n;
    vecs[0] = '{"k1_idx1",  K1, 4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
    vecs[1] = '{"k1_idx10", K1, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vecs[2] = '{"k1_idx0",  K1, 4'd0,  K1};
    vecs[3] = '{"k1_idx11", K1, 4'd11, 128'h0};
    vecs[4] = '{"k1_idx15", K1, 4'd15, 128'h0};
    vecs[5] = '{"k2_idx10", K2, 4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5};
    vecs[6] = '{"k0_idx1",  K0, 4'd1,  128'h62636363626363636263636362636363};
    vecs[7] = '{"k0_idx12", K0, 4'd12, 128'h0};

    build_sbox();
    Reset = 1'b1; start = 1'b0; rd_idx = 4'd0; cipher_key = '0;
    tick; tick;
    chk("rst_busy", 128'(busy), 128'h0);
    chk("rst_ready", 128'(ready), 128'h0);
    chk("rst_round_key", round_key, 128'h0);
    mon_en = 1'b1;
    Reset  = 1'b0;
    tick;
    rd(4'd0, 128'h0, "rd_not_ready");

    // Basic expansion and latency
    load(K1);
    chk("t1_busy_c1", 128'(busy), 128'h1);
    chk("t1_ready_c1", 128'(ready), 128'h0);
    wait_ready(n);
    chk("t1_latency", 128'(n), 128'd11);
    chk("t1_busy_done", 128'(busy), 128'h0);

    // Table-driven spot vectors
    for (int i = 0; i < 8; i++) begin
      if (i == 5 || i == 6) begin
        load(vecs[i].key);
        wait_ready(n);
        chk({vecs[i].name, "_latency"}, 128'(n), 128'd11);
      end
      rd(vecs[i].idx, vecs[i].exp, vecs[i].name);
    end

    // Start mid-expansion is ignored
    compute_sched(K1);
    load(K1);
    n = 1;
    while (n < 5) begin tick; n++; end
    start = 1'b1; cipher_key = K2;
    tick; n++;
    start = 1'b0;
    chk("t3_still_busy", 128'(busy), 128'h1);
    while (!ready && n < 40) begin tick; n++; end
    chk("t3_latency", 128'(n), 128'd11);
    // Step indices 10 down to 0, one per cycle
    for (int i = 10; i >= 0; i--) rd(4'(i), ks[i], $sformatf("step_idx%0d", i));

    // Restart from READY while reading: read returns old key
    start = 1'b1; cipher_key = K2; rd_idx = 4'd1;
    begin
      sb_t e;
      e.exp = ks[1]; e.due = cyc + 1; e.name = "restart_read_old";
      sbq.push_back(e);
    end
    tick;
    start = 1'b0;
    chk("restart_ready_drop", 128'(ready), 128'h0);
    chk("restart_busy", 128'(busy), 128'h1);
    wait_ready(n);
    chk("restart_latency", 128'(n), 128'd11);
    rd(4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5, "restart_k2_idx10");

    // Reset mid-expansion aborts
    load(K1);
    n = 1;
    while (n < 6) begin tick; n++; end
    Reset = 1'b1;
    tick;
    Reset = 1'b0;
    chk("abort_busy", 128'(busy), 128'h0);
    chk("abort_ready", 128'(ready), 128'h0);
    chk("abort_round_key", round_key, 128'h0);
    rd(4'd10, 128'h0, "abort_rd10");
    rd(4'd0, 128'h0, "abort_rd0");
    repeat (12) tick;
    chk("abort_no_restart", 128'(ready | busy), 128'h0);

    // Rekey with zero key: every entry follows the zero-key schedule
    compute_sched(K0);
    load(K0);
    wait_ready(n);
    chk("k0_latency", 128'(n), 128'd11);
    for (int i = 0; i <= 10; i++) rd(4'(i), ks[i], $sformatf("k0_idx%0d", i));
    tick;
    chk("k0_model_r1", ks[1], 128'h62636363626363636263636362636363);
    chk("sb_drained", 128'(sbq.size()), 128'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
